// File: rtl/pipelined_addsub_if.sv
// Handshake bundle for pipelined_addsub: operand beat in, result beat out.
// slave = the arithmetic unit, master = the producer/consumer driving it.
interface pipelined_addsub_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned FLAG_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_a;
  logic [WIDTH-1:0]  in_b;
  logic              in_sub;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_y;
  logic [FLAG_W-1:0] out_flags;

  modport slave (
    input  in_valid, in_a, in_b, in_sub, out_ready,
    output in_ready, out_valid, out_y, out_flags
  );

  modport master (
    output in_valid, in_a, in_b, in_sub, out_ready,
    input  in_ready, out_valid, out_y, out_flags
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Two-stage pipelined adder/subtractor with {V,B,N,Z} flags and valid/ready handshake.
// Optional ADDSUB_SATURATE_EN clamps signed overflow to the signed limit.
module pipelined_addsub #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned FLAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  pipelined_addsub_if.slave  bus
);
  localparam int unsigned MSB = WIDTH - 1;

  logic              adv;
  logic              s1_valid;
  logic [WIDTH-1:0]  s1_a;
  logic [WIDTH-1:0]  s1_b;
  logic              s1_sub;
  logic              out_valid_q;
  logic [WIDTH-1:0]  y_q;
  logic [FLAG_W-1:0] flags_q;

  logic [WIDTH-1:0]  bop;
  logic [WIDTH:0]    sum;
  logic [WIDTH-1:0]  s_raw;
  logic              carry;
  logic              ovf;
  logic              borrow;
  logic [WIDTH-1:0]  y_next;
  logic [FLAG_W-1:0] flags_next;

  // Whole pipe advances together; a stalled output freezes stage 1 as well.
  assign adv          = !out_valid_q || bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.out_y     = y_q;
  assign bus.out_flags = flags_q;

  always_comb begin
    bop    = s1_sub ? ~s1_b : s1_b;
    sum    = {1'b0, s1_a} + {1'b0, bop} + {{WIDTH{1'b0}}, s1_sub};
    s_raw  = sum[WIDTH-1:0];
    carry  = sum[WIDTH];
    borrow = s1_sub ? ~carry : carry;
    ovf    = (s1_a[MSB] == bop[MSB]) && (s_raw[MSB] != s1_a[MSB]);
`ifdef ADDSUB_SATURATE_EN
    if (ovf)
      y_next = s1_a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      y_next = s_raw;
`else
    y_next = s_raw;
`endif
    flags_next = {ovf, borrow, y_next[MSB], (y_next == '0)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sub   <= 1'b0;
    end else if (adv) begin
      s1_valid <= bus.in_valid;
      s1_a     <= bus.in_a;
      s1_b     <= bus.in_b;
      s1_sub   <= bus.in_sub;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      flags_q     <= '0;
    end else if (adv) begin
      out_valid_q <= s1_valid;
      y_q         <= y_next;
      flags_q     <= flags_next;
    end
  end
endmodule
